fifo_uart_tx: RTL and testbench

Serial transmit stage downstream of the 8-bit synchronous FIFO. Pops one byte at a time from the FIFO read port and serialises it as an asynchronous UART frame: start bit, 8 data bits LSB first, optional parity, one stop bit. It drains the FIFO back-to-back while bytes are available and idles line-high otherwise.

---
 rtl/fifo_uart_tx.sv | 115 +++++++++++
 tb/tb_fifo_uart_tx.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/fifo_uart_tx.sv
// UART transmitter that drains a synchronous FIFO one byte at a time.
// Frame: start bit, 8 data bits LSB first, optional parity, one stop bit.
module fifo_uart_tx #(
  parameter int CLKS_PER_BIT = 868,
  parameter bit PARITY_EN    = 1'b0,
  parameter bit PARITY_ODD   = 1'b0
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       fifo_empty_i,
  input  logic [7:0] fifo_data_i,
  output logic       fifo_rd_en_o,
  output logic       tx_o,
  output logic       busy_o,
  output logic       tx_done_o
);

  localparam int CW = $clog2(CLKS_PER_BIT);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    START,
    DATA,
    PARITY,
    STOP
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    shift_q, shift_d;
  logic          parity_q, parity_d;
  logic          tx_q, tx_d;
  logic          bit_end;

  assign bit_end = (cnt_q == CW'(CLKS_PER_BIT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      bit_q    <= '0;
      shift_q  <= '0;
      parity_q <= 1'b0;
      tx_q     <= 1'b1;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      bit_q    <= bit_d;
      shift_q  <= shift_d;
      parity_q <= parity_d;
      tx_q     <= tx_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    bit_d    = bit_q;
    shift_d  = shift_q;
    parity_d = parity_q;

    case (state_q)
      IDLE: begin
        if (!fifo_empty_i) state_d = FETCH;
      end
      FETCH: begin
        state_d = LOAD;
      end
      LOAD: begin
        // Read data is valid here, one cycle after the FETCH strobe.
        shift_d  = fifo_data_i;
        parity_d = (^fifo_data_i) ^ PARITY_ODD;
        cnt_d    = '0;
        bit_d    = '0;
        state_d  = START;
      end
      START, DATA, PARITY, STOP: begin
        cnt_d = bit_end ? '0 : cnt_q + 1'b1;
        if (bit_end) begin
          case (state_q)
            START:  state_d = DATA;
            DATA: begin
              shift_d = shift_q >> 1;
              bit_d   = bit_q + 3'd1;
              if (bit_q == 3'd7) state_d = PARITY_EN ? PARITY : STOP;
            end
            PARITY: state_d = STOP;
            default: state_d = fifo_empty_i ? IDLE : FETCH;
          endcase
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // Line level is registered from the next state so it switches exactly at bit boundaries.
  always_comb begin
    tx_d = 1'b1;
    case (state_d)
      START:   tx_d = 1'b0;
      DATA:    tx_d = shift_d[0];
      PARITY:  tx_d = parity_d;
      default: tx_d = 1'b1;
    endcase
  end

  assign fifo_rd_en_o = (state_q == FETCH);
  assign busy_o       = (state_q != IDLE);
  assign tx_done_o    = (state_q == STOP) && bit_end;
  assign tx_o         = tx_q;

endmodule

// File: tb/tb_fifo_uart_tx.sv
// Directed bench: three transmitters (no parity, even, odd) at 4 clocks/bit, each fed by a small FIFO model.
module tb_fifo_uart_tx;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic [2:0] hold = 3'b000;
  logic [2:0] empty_w, rd_w, tx_w, busy_w, done_w;
  logic [7:0] data_w [3];
  logic [7:0] mem [3][16];
  int         wr_ptr [3] = '{0, 0, 0};
  int         rd_ptr [3] = '{0, 0, 0};
  int         rd_cnt [3] = '{0, 0, 0};
  int         viol   [3] = '{0, 0, 0};
  int         tests = 0;
  int         failed = 0;

  always #5 clk = ~clk;

  for (genvar gi = 0; gi < 3; gi++) begin : g_dut
    fifo_uart_tx #(
      .CLKS_PER_BIT(4),
      .PARITY_EN   (gi > 0),
      .PARITY_ODD  (gi == 2)
    ) u_dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .fifo_empty_i(empty_w[gi]),
      .fifo_data_i (data_w[gi]),
      .fifo_rd_en_o(rd_w[gi]),
      .tx_o        (tx_w[gi]),
      .busy_o      (busy_w[gi]),
      .tx_done_o   (done_w[gi])
    );
  end

  // FIFO model: registered read data, empty can be forced high by hold.
  always_comb begin
    for (int i = 0; i < 3; i++) empty_w[i] = (rd_ptr[i] == wr_ptr[i]) || hold[i];
  end

  always @(posedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) begin
        data_w[i] <= mem[i][rd_ptr[i] % 16];
        rd_ptr[i] <= rd_ptr[i] + 1;
      end
    end
  end

  always @(negedge clk) begin
    for (int i = 0; i < 3; i++) begin
      if (rd_w[i]) rd_cnt[i]++;
      if (rd_w[i] && empty_w[i]) viol[i]++;
    end
  end

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      failed++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic push(input int inst, input logic [7:0] b);
    mem[inst][wr_ptr[inst] % 16] = b;
    wr_ptr[inst]++;
    $display("[TB] push inst%0d byte %02h", inst, b);
  endtask

  // Next negedge must fall in the first start-bit cycle.
  task automatic expect_frame(input int inst, input logic [7:0] b, input bit pe,
                              input bit par, input string name);
    logic [10:0] lv;
    int          nbits;
    lv     = '1;
    lv[0]  = 1'b0;
    lv[8:1] = b;
    if (pe) lv[9] = par;
    nbits = pe ? 11 : 10;
    for (int k = 0; k < nbits * 4; k++) begin
      @(negedge clk);
      check_val($sformatf("%s_tx%0d", name, k), tx_w[inst], lv[k / 4]);
      check_val($sformatf("%s_busy%0d", name, k), busy_w[inst], 1);
      check_val($sformatf("%s_done%0d", name, k), done_w[inst], (k == nbits * 4 - 1));
    end
    $display("[TB] frame %s inst%0d byte %02h checked (%0d bits)", name, inst, b, nbits);
  endtask

  // Called right after a push at cycle T: covers T, T+1 (FETCH) and T+2 (LOAD).
  task automatic expect_fetch(input int inst, input string name);
    @(negedge clk);
    check_val({name, "_rd_T"}, rd_w[inst], 0);
    @(negedge clk);
    check_val({name, "_rd_T1"}, rd_w[inst], 1);
    check_val({name, "_busy_T1"}, busy_w[inst], 1);
    @(negedge clk);
    check_val({name, "_rd_T2"}, rd_w[inst], 0);
    check_val({name, "_tx_T2"}, tx_w[inst], 1);
  endtask

  task automatic expect_idle(input int inst, input string name);
    @(negedge clk);
    check_val({name, "_idle_busy"}, busy_w[inst], 0);
    check_val({name, "_idle_tx"}, tx_w[inst], 1);
    check_val({name, "_idle_rd"}, rd_w[inst], 0);
  endtask

  initial begin
    // Reset state and quiet idling with empty FIFOs
    repeat (3) @(posedge clk);
    @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("rst_tx%0d", i), tx_w[i], 1);
      check_val($sformatf("rst_busy%0d", i), busy_w[i], 0);
      check_val($sformatf("rst_rd%0d", i), rd_w[i], 0);
      check_val($sformatf("rst_done%0d", i), done_w[i], 0);
    end
    @(posedge clk); #1 rst_n = 1'b1;
    repeat (20) @(negedge clk);
    for (int i = 0; i < 3; i++) begin
      check_val($sformatf("idle_rdcnt%0d", i), rd_cnt[i], 0);
      check_val($sformatf("idle_busy%0d", i), busy_w[i], 0);
      check_val($sformatf("idle_tx%0d", i), tx_w[i], 1);
    end

    // Single byte 0xA5
    @(posedge clk); #1 push(0, 8'hA5);
    expect_fetch(0, "a5");
    expect_frame(0, 8'hA5, 1'b0, 1'b0, "a5");
    expect_idle(0, "a5");
    check_val("a5_rdcnt", rd_cnt[0], 1);

    // Back-to-back 0x00 then 0xFF, two idle-high cycles between frames
    @(posedge clk); #1 push(0, 8'h00); push(0, 8'hFF);
    expect_fetch(0, "b2b");
    expect_frame(0, 8'h00, 1'b0, 1'b0, "b2b0");
    @(negedge clk);
    check_val("b2b_gap_rd", rd_w[0], 1);
    check_val("b2b_gap_tx0", tx_w[0], 1);
    check_val("b2b_gap_busy0", busy_w[0], 1);
    @(negedge clk);
    check_val("b2b_gap_rd1", rd_w[0], 0);
    check_val("b2b_gap_tx1", tx_w[0], 1);
    check_val("b2b_gap_busy1", busy_w[0], 1);
    expect_frame(0, 8'hFF, 1'b0, 1'b0, "b2b1");
    expect_idle(0, "b2b");
    check_val("b2b_rdcnt", rd_cnt[0], 3);

    // Parity on 0x07: even gives 1, odd gives 0
    @(posedge clk); #1 push(1, 8'h07); push(2, 8'h07);
    expect_fetch(1, "par");
    fork
      expect_frame(1, 8'h07, 1'b1, 1'b1, "par_even");
      expect_frame(2, 8'h07, 1'b1, 1'b0, "par_odd");
    join
    expect_idle(1, "par_even");
    check_val("par_odd_busy", busy_w[2], 0);
    check_val("par_rdcnt1", rd_cnt[1], 1);
    check_val("par_rdcnt2", rd_cnt[2], 1);

    // Reset in the middle of data bit 3 (0x35 has bit3 = 0)
    @(posedge clk); #1 push(0, 8'h35); push(0, 8'h81);
    repeat (3) @(negedge clk);
    repeat (17) @(negedge clk);
    check_val("mid_bit3_tx", tx_w[0], 0);
    rst_n = 1'b0;
    #1;
    check_val("mid_rst_tx", tx_w[0], 1);
    check_val("mid_rst_busy", busy_w[0], 0);
    check_val("mid_rst_rd", rd_w[0], 0);
    check_val("mid_rst_done", done_w[0], 0);
    $display("[TB] reset asserted mid-frame");
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    expect_fetch(0, "mid");
    expect_frame(0, 8'h81, 1'b0, 1'b0, "mid81");
    expect_idle(0, "mid");
    check_val("mid_rdcnt", rd_cnt[0], 5);

    // Forced empty: no reads; toggling during the frame adds none
    hold[0] = 1'b1;
    push(0, 8'h55); push(0, 8'h66);
    repeat (10) @(negedge clk);
    check_val("hold_rdcnt", rd_cnt[0], 5);
    check_val("hold_busy", busy_w[0], 0);
    @(posedge clk); #1 hold[0] = 1'b0;
    expect_fetch(0, "tog");
    fork
      expect_frame(0, 8'h55, 1'b0, 1'b0, "tog55");
      begin
        repeat (8) @(posedge clk);
        repeat (24) begin
          @(posedge clk); #1 hold[0] = ~hold[0];
        end
        hold[0] = 1'b1;
      end
    join
    expect_idle(0, "tog");
    repeat (5) @(negedge clk);
    check_val("tog_rdcnt", rd_cnt[0], 6);
    check_val("tog_busy", busy_w[0], 0);
    @(posedge clk); #1 hold[0] = 1'b0;
    expect_fetch(0, "tog2");
    expect_frame(0, 8'h66, 1'b0, 1'b0, "tog66");
    expect_idle(0, "tog2");
    check_val("tog2_rdcnt", rd_cnt[0], 7);

    for (int i = 0; i < 3; i++) check_val($sformatf("underflow%0d", i), viol[i], 0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
